arb_mux_nxw: RTL

//  Registered N-channel, W-bit multiplexer; parametrised successor of the 4-way multibit mux.

---
 rtl/arb_mux_nxw.sv | 124 ++++++++++++
 1 files changed

// File: rtl/arb_mux_nxw.sv
// Registered N-channel W-bit multiplexer with fixed-select or round-robin grant and valid/ready output stage.
// Optional feature: define ARBMUX_PARITY_EN to add the registered out_par output.
module arb_mux_nxw #(
   parameter int WIDTH = 4,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
`ifdef ARBMUX_PARITY_EN
   output logic                 out_par,
`endif
   input  logic                 out_ready
);

`ifdef ARBMUX_PARITY_EN
   function automatic logic calc_par(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction
   logic out_par_r;
`endif

   logic [WIDTH-1:0] out_data_r;
   logic [SELW-1:0]  out_ch_r;
   logic             out_valid_r;
   logic [SELW-1:0]  rr_ptr_r;

   logic             load_s;
   logic             grant_valid_s;
   logic [SELW-1:0]  grant_idx_s;
   logic [WIDTH-1:0] grant_data_s;
   logic [NCH-1:0]   in_ready_s;
   int               idx_v;

   assign load_s = ~out_valid_r | out_ready;

   // Grant selection: fixed index in mode 0, first valid channel from rr_ptr in mode 1.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_idx_s   = '0;
      idx_v         = 0;
      if (mode == 1'b0) begin
         if (int'(sel) < NCH) begin
            grant_valid_s = in_valid[sel];
            grant_idx_s   = sel;
         end else begin
            grant_valid_s = 1'b0;
            grant_idx_s   = '0;
         end
      end else begin
         // Scan from the farthest offset down so the nearest valid channel wins.
         for (int k = NCH - 1; k >= 0; k--) begin
            idx_v = int'(rr_ptr_r) + k;
            if (idx_v >= NCH) begin
               idx_v = idx_v - NCH;
            end else begin
               idx_v = idx_v;
            end
            if (in_valid[idx_v]) begin
               grant_valid_s = 1'b1;
               grant_idx_s   = SELW'(idx_v);
            end else begin
               grant_valid_s = grant_valid_s;
               grant_idx_s   = grant_idx_s;
            end
         end
      end
   end

   assign grant_data_s = in_data[grant_idx_s*WIDTH +: WIDTH];

   // One-hot ready toward the granted channel, forced low during reset.
   always_comb begin
      in_ready_s = '0;
      for (int i = 0; i < NCH; i++) begin
         in_ready_s[i] = rst_n & load_s & grant_valid_s & (grant_idx_s == SELW'(i));
      end
   end

   assign in_ready = in_ready_s;

   // Output register and round-robin pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= '0;
         out_ch_r    <= '0;
         out_valid_r <= 1'b0;
         rr_ptr_r    <= '0;
`ifdef ARBMUX_PARITY_EN
         out_par_r   <= 1'b0;
`endif
      end else if (load_s) begin
         if (grant_valid_s) begin
            out_data_r  <= grant_data_s;
            out_ch_r    <= grant_idx_s;
            out_valid_r <= 1'b1;
`ifdef ARBMUX_PARITY_EN
            out_par_r   <= calc_par(grant_data_s);
`endif
            if (mode == 1'b1) begin
               rr_ptr_r <= (grant_idx_s == SELW'(NCH - 1)) ? '0 : grant_idx_s + SELW'(1);
            end
         end else begin
            out_valid_r <= 1'b0;
         end
      end
   end

   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;
   assign out_valid = out_valid_r;
`ifdef ARBMUX_PARITY_EN
   assign out_par   = out_par_r;
`endif

endmodule
